// File: rtl/ctrl_pkg.sv
// Shared control-word layout for the decoder and the execute/writeback stage.
// Bit positions, operand/PC-source encodings, ALU opcodes and regs_in field slices.
package ctrl_pkg;

    localparam int CW_ESC_COND_CP = 0;
    localparam int CW_ESC_CP      = 1;
    localparam int CW_ULA_A       = 2;
    localparam int CW_ULA_B_LO    = 3;
    localparam int CW_ULA_B_HI    = 4;
    localparam int CW_ESC_IR      = 5;
    localparam int CW_FONTE_LO    = 6;
    localparam int CW_FONTE_HI    = 7;
    localparam int CW_ESC_REG     = 8;
    localparam int CW_MUL         = 10;
    localparam int CW_OP_LO       = 11;
    localparam int CW_OP_HI       = 14;

    typedef enum logic [1:0] {
        UB_RT   = 2'b00,
        UB_ONE  = 2'b01,
        UB_IMM  = 2'b10,
        UB_ZERO = 2'b11
    } ula_b_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_BR   = 2'b01,
        PC_JMP  = 2'b10,
        PC_INC3 = 2'b11
    } fonte_cp_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADD2 = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADD8 = 4'd8;
    localparam logic [3:0] OP_SUB9 = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_ADDB = 4'd11;
    localparam logic [3:0] OP_SUBC = 4'd12;
    localparam logic [3:0] OP_NOTA = 4'd13;
    localparam logic [3:0] OP_PASB = 4'd14;

    // Field order mirrors the bit map, MSB first.
    typedef struct packed {
        logic      rsv15;
        logic [3:0] op;
        logic      mul;
        logic      rsv9;
        logic      esc_reg;
        fonte_cp_e fonte;
        logic      esc_ir;
        ula_b_e    ula_b;
        logic      ula_a;
        logic      esc_cp;
        logic      esc_cond_cp;
    } ctrl_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } mstate_e;

    function automatic logic [3:0] rd_f(input logic [11:0] r);
        return r[11:8];
    endfunction

    function automatic logic [3:0] rs_f(input logic [11:0] r);
        return r[7:4];
    endfunction

    function automatic logic [3:0] rt_f(input logic [11:0] r);
        return r[3:0];
    endfunction

endpackage

// File: rtl/ctrl_word_exec_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, low DW bits kept.
// done is high during the cycle whose edge performs the final step.
module mul_seq #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] prod
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    logic [DW-1:0] a_q, b_q, acc_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_LAST);
    assign prod = acc_q;

endmodule

// File: rtl/ctrl_word_exec.sv
// Execute/writeback stage driven by the decoder's control word: operand select,
// ALU, iterative multiply, PC update and the register file.
module ctrl_word_exec
    import ctrl_pkg::*;
#(
    parameter int             DW     = 16,
    parameter int             NREG   = 16,
    parameter logic [DW-1:0]  PC_RST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   ctrl_in,
    input  logic [11:0]   regs_in,
    input  logic          valid_in,
    output logic          stall,
    output logic [DW-1:0] pc,
    output logic          wb_en,
    output logic [3:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          zero
);
    ctrl_t c;
    assign c = ctrl_t'(ctrl_in);

    logic [3:0] rd, rs, rt;
    assign rd = rd_f(regs_in);
    assign rs = rs_f(regs_in);
    assign rt = rt_f(regs_in);

    logic [NREG-1:0][DW-1:0] rf_q;
    logic [DW-1:0]           pc_q, pc_d, wb_data_q, wb_data_d;
    logic [3:0]              wb_addr_q, wb_addr_d, mrd_q, wa;
    logic                    wb_en_q, wb_en_d, zero_q, zero_d, mwr_q, we;
    logic [DW-1:0]           wd;
    mstate_e                 state_q, state_d;

    logic [DW-1:0] r_rs, r_rt, r_rd, op_a, op_b, imm_sx, alu_res, pc_next;
    assign r_rs   = (rs == 4'd0) ? '0 : rf_q[rs];
    assign r_rt   = (rt == 4'd0) ? '0 : rf_q[rt];
    assign r_rd   = (rd == 4'd0) ? '0 : rf_q[rd];
    assign imm_sx = {{(DW-4){rt[3]}}, rt};
    assign op_a   = c.ula_a ? r_rs : pc_q;

    always_comb begin
        op_b = '0;
        unique case (c.ula_b)
            UB_RT:   op_b = r_rt;
            UB_ONE:  op_b = {{(DW-1){1'b0}}, 1'b1};
            UB_IMM:  op_b = imm_sx;
            default: op_b = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (c.op)
            OP_ADD, OP_ADD2, OP_ADD8, OP_ADDB: alu_res = op_a + op_b;
            OP_SUB, OP_SUB9, OP_SUBC:          alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[3:0];
            OP_SHR:  alu_res = op_a >> op_b[3:0];
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOTA: alu_res = ~op_a;
            OP_PASB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        pc_next = pc_q + 1'b1;
        case (c.fonte)
            PC_BR:   if (c.esc_cond_cp && (r_rd == r_rs)) pc_next = pc_q + imm_sx;
            PC_JMP:  pc_next = {pc_q[DW-1:12], regs_in};
            default: pc_next = pc_q + 1'b1;
        endcase
    end

    // Acceptance is gated by the FSM state, not by stall: stall already rises
    // combinationally in the accept cycle of a multiply.
    logic accept, mul_start, mul_done, mul_busy;
    logic [DW-1:0] mul_prod;
    assign accept    = valid_in && (state_q == MS_IDLE);
    assign mul_start = accept && c.mul;
    assign stall     = (state_q != MS_IDLE) || mul_start;

    mul_seq #(.DW(DW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (r_rs),
        .b     (r_rt),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        zero_d    = zero_q;
        we        = 1'b0;
        wa        = rd;
        wd        = alu_res;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            MS_IDLE: begin
                if (accept) begin
                    if (c.mul) begin
                        state_d = MS_BUSY;
                    end else begin
                        zero_d = (alu_res == '0);
                        we     = c.esc_reg && (rd != 4'd0);
                        if (c.esc_cp) pc_d = pc_next;
                    end
                end
            end
            MS_BUSY: if (mul_done) state_d = MS_DONE;
            MS_DONE: begin
                state_d = MS_IDLE;
                pc_d    = pc_q + 1'b1;
                we      = mwr_q && (mrd_q != 4'd0);
                wa      = mrd_q;
                wd      = mul_prod;
            end
            default: state_d = MS_IDLE;
        endcase
        if (we) begin
            wb_en_d   = 1'b1;
            wb_addr_d = wa;
            wb_data_d = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MS_IDLE;
            pc_q      <= PC_RST;
            zero_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mrd_q     <= '0;
            mwr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            zero_q    <= zero_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            if (mul_start) begin
                mrd_q <= rd;
                mwr_q <= c.esc_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rf_q     <= '0;
        else if (we) rf_q[wa] <= wd;
    end

    logic unused_ok;
    assign unused_ok = ^{c.rsv15, c.rsv9, c.esc_ir, mul_busy};

    assign pc      = pc_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_ctrl_word_exec.sv
// Randomized and directed bench for ctrl_word_exec against a behavioural model
// of registers, PC and zero flag.
module tb_ctrl_word_exec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ctrl_in = '0;
    logic [11:0] regs_in = '0;
    logic        valid_in = 1'b0;
    logic        stall, wb_en, zero;
    logic [15:0] pc, wb_data;
    logic [3:0]  wb_addr;

    ctrl_word_exec #(.DW(16), .NREG(16), .PC_RST(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .regs_in(regs_in),
        .valid_in(valid_in), .stall(stall), .pc(pc), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .zero(zero)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_r [16];
    logic [15:0] m_pc;
    logic        m_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rv(input logic [3:0] i);
        return (i == 4'd0) ? 16'd0 : m_r[i];
    endfunction

    function automatic logic [15:0] sx4(input logic [3:0] v);
        int s;
        s = (v >= 4'd8) ? int'(v) - 16 : int'(v);
        return 16'(s);
    endfunction

    function automatic int sgn(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ai, bi, sh;
        ai = int'(a); bi = int'(b); sh = int'(b) % 16;
        case (op)
            4'd0, 4'd2, 4'd8, 4'd11: return 16'(ai + bi);
            4'd1, 4'd9, 4'd12:       return 16'(ai - bi);
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return 16'(ai * (1 << sh));
            4'd7:  return 16'(ai / (1 << sh));
            4'd10: return (sgn(a) < sgn(b)) ? 16'd1 : 16'd0;
            4'd13: return 16'(65535 - ai);
            4'd14: return b;
            default: return 16'd0;
        endcase
    endfunction

    // op, ULA_A, ULA_B, FonteCP, EscCP, EscCondCP, EscReg, Mul
    function automatic logic [15:0] mk(input int op, input bit ua, input int ub, input int fc,
                                       input bit ecp, input bit cond, input bit ereg, input bit mul);
        return {1'b0, 4'(op), mul, 1'b0, ereg, 2'(fc), 1'b0, 2'(ub), ua, ecp, cond};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 16'd0;
        m_pc   = 16'h0000;
        m_zero = 1'b0;
    endtask

    task automatic mul_issue(input logic [15:0] cw, input logic [11:0] rg);
        logic [15:0] p;
        logic [3:0]  rd;
        bit          we;
        int          cnt;
        rd  = rg[11:8];
        p   = 16'(32'(rv(rg[7:4])) * 32'(rv(rg[3:0])));
        we  = cw[8] && (rd != 4'd0);
        ctrl_in = cw; regs_in = rg; valid_in = 1'b1;
        #1 check("mul_stall_acc", stall, 1'b1);
        @(posedge clk);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall) break;
            cnt++;
            check("mul_pc_hold", pc, m_pc);
            check("mul_wb_quiet", wb_en, 1'b0);
            ctrl_in  = 16'($urandom) & ~16'h0400;
            regs_in  = 12'($urandom);
            valid_in = 1'b1;
            @(posedge clk);
        end
        valid_in = 1'b0;
        if (we) m_r[rd] = p;
        m_pc = m_pc + 16'd1;
        check("mul_cycles", cnt, 18);
        check("mul_wb_en", wb_en, we);
        if (we) begin
            check("mul_wb_addr", wb_addr, rd);
            check("mul_wb_data", wb_data, p);
        end
        check("mul_pc", pc, m_pc);
    endtask

    task automatic issue(input logic [15:0] cw, input logic [11:0] rg);
        logic [15:0] a, b, res, npc;
        logic [3:0]  rd, rs, rt;
        bit          we;
        if (cw[10]) begin
            mul_issue(cw, rg);
            return;
        end
        rd = rg[11:8]; rs = rg[7:4]; rt = rg[3:0];
        a = cw[2] ? rv(rs) : m_pc;
        case (cw[4:3])
            2'b00:   b = rv(rt);
            2'b01:   b = 16'd1;
            2'b10:   b = sx4(rt);
            default: b = 16'd0;
        endcase
        res = alu_ref(cw[14:11], a, b);
        npc = m_pc;
        if (cw[1]) begin
            case (cw[7:6])
                2'b01:   npc = (cw[0] && rv(rd) == rv(rs)) ? m_pc + sx4(rt) : m_pc + 16'd1;
                2'b10:   npc = {m_pc[15:12], rg};
                default: npc = m_pc + 16'd1;
            endcase
        end
        we = cw[8] && (rd != 4'd0);
        ctrl_in = cw; regs_in = rg; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        if (we) m_r[rd] = res;
        m_pc   = npc;
        m_zero = (res == 16'd0);
        check("wb_en", wb_en, we);
        if (we) begin
            check("wb_addr", wb_addr, rd);
            check("wb_data", wb_data, res);
        end
        check("pc", pc, m_pc);
        check("zero", zero, m_zero);
        check("stall", stall, 1'b0);
    endtask

    task automatic idle_cycle(input logic [15:0] cw, input logic [11:0] rg);
        ctrl_in = cw; regs_in = rg; valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("idle_pc", pc, m_pc);
        check("idle_wb_en", wb_en, 1'b0);
        check("idle_stall", stall, 1'b0);
    endtask

    task automatic set_reg(input logic [3:0] x, input logic [15:0] v);
        issue(mk(14, 0, 3, 0, 0, 0, 1, 0), {x, 8'h00});
        for (int i = 15; i >= 0; i--) begin
            issue(mk(0, 1, 0, 0, 0, 0, 1, 0), {x, x, x});
            if (v[i]) issue(mk(0, 1, 1, 0, 0, 0, 1, 0), {x, x, 4'h0});
        end
    endtask

    task automatic read_reg(input logic [3:0] x);
        issue(mk(14, 0, 0, 0, 0, 0, 1, 0), {4'hF, 4'h0, x});
    endtask

    task automatic step_pc();
        issue(mk(0, 0, 0, 0, 1, 0, 0, 0), 12'h000);
    endtask

    task automatic jump(input logic [11:0] t);
        issue(mk(0, 0, 0, 2, 1, 0, 0, 0), t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] cw;
        logic [11:0] rg;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_stall", stall, 1'b0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_wb_addr", wb_addr, 4'd0);
        check("rst_wb_data", wb_data, 16'd0);
        check("rst_zero", zero, 1'b0);

        // ADD R3 = R1 + R2
        set_reg(4'd1, 16'd5);
        set_reg(4'd2, 16'd7);
        issue(mk(0, 1, 0, 0, 1, 0, 1, 0), 12'h312);
        check("t1_wb_en", wb_en, 1'b1);
        check("t1_wb_addr", wb_addr, 4'd3);
        check("t1_wb_data", wb_data, 16'd12);
        check("t1_pc", pc, 16'h0001);

        // Conditional branch taken / not taken
        set_reg(4'd1, 16'd9);
        set_reg(4'd2, 16'd9);
        jump(12'h010);
        issue(mk(0, 0, 0, 1, 1, 1, 0, 0), 12'h12E);
        check("t2_taken", pc, 16'h000E);
        set_reg(4'd2, 16'd8);
        jump(12'h010);
        issue(mk(0, 0, 0, 1, 1, 1, 0, 0), 12'h12E);
        check("t2_not_taken", pc, 16'h0011);

        // Walk the upper nibble to 3 then jump keeps it
        for (int i = 0; i < 3; i++) begin
            jump(12'hFFF);
            step_pc();
        end
        jump(12'h456);
        check("t3_pre", pc, 16'h3456);
        jump(12'hABC);
        check("t3_pc", pc, 16'h3ABC);
        check("t3_wb_en", wb_en, 1'b0);

        // Multiply
        set_reg(4'd1, 16'd300);
        set_reg(4'd2, 16'd7);
        issue(mk(0, 1, 0, 0, 1, 0, 1, 1), 12'h412);
        read_reg(4'd4);
        check("t4_r4", wb_data, 16'd2100);
        set_reg(4'd1, 16'h0100);
        set_reg(4'd2, 16'h0100);
        issue(mk(0, 1, 0, 0, 0, 0, 1, 1), 12'h412);
        read_reg(4'd4);
        check("t4_wrap", wb_data, 16'h0000);

        // Reset in the middle of a multiply
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_reg(4'd1, 16'd11);
        set_reg(4'd2, 16'd13);
        ctrl_in = mk(0, 1, 0, 0, 1, 0, 1, 1); regs_in = 12'h412; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("t5_busy", stall, 1'b1);
            @(posedge clk);
            #1;
        end
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_stall", stall, 1'b0);
        check("t5_pc", pc, 16'h0000);
        check("t5_wb_en", wb_en, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 check("t5_no_wb", wb_en, 1'b0);
        end
        read_reg(4'd4);
        check("t5_r4", wb_data, 16'd0);

        // Write to R0 dropped; idle cycle holds pc
        set_reg(4'd1, 16'd3);
        set_reg(4'd2, 16'd4);
        issue(mk(0, 1, 0, 0, 1, 0, 1, 0), 12'h012);
        check("t6_wb_en", wb_en, 1'b0);
        idle_cycle(mk(0, 1, 0, 0, 1, 0, 1, 0), 12'h312);
        read_reg(4'd0);
        check("t6_r0", wb_data, 16'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            cw = 16'($urandom);
            rg = 12'($urandom);
            if (cw[14:11] == 4'hF) cw[14:11] = 4'h0;
            if ($urandom_range(7) != 0) cw[10] = 1'b0;
            if ($urandom_range(5) == 0) idle_cycle(cw, rg);
            else issue(cw, rg);
        end
        for (int i = 1; i < 16; i++) read_reg(4'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
